// File: rtl/acc_int_add_pkg.sv
// Shared constants and helpers for the exact integer adder and its lookahead slices.
// Group size is fixed at 4 bits; the group count rounds the operand width up.
package acc_int_add_pkg;

  localparam int CLA_GRP = 4;

  function automatic int cla_num_groups(input int width);
    return (width + CLA_GRP - 1) / CLA_GRP;
  endfunction

endpackage

// File: rtl/acc_cla4_group.sv
// 4-bit carry-lookahead slice: internal carries from bit generate/propagate terms,
// plus group generate/propagate for the group-level carry ripple in the parent.
module acc_cla4_group
  import acc_int_add_pkg::*;
(
  input  logic [CLA_GRP-1:0] a,
  input  logic [CLA_GRP-1:0] b,
  input  logic               cin,
  output logic [CLA_GRP-1:0] s,
  output logic               g,
  output logic               p,
  output logic               cout
);

  logic [CLA_GRP-1:0] bit_g;
  logic [CLA_GRP-1:0] bit_p;
  logic [CLA_GRP-1:0] bit_c;

  assign bit_g = a & b;
  assign bit_p = a ^ b;

  // Every carry is a flat sum of products over cin, so no ripple inside the slice.
  assign bit_c[0] = cin;
  assign bit_c[1] = bit_g[0]
                  | (bit_p[0] & cin);
  assign bit_c[2] = bit_g[1]
                  | (bit_p[1] & bit_g[0])
                  | (bit_p[1] & bit_p[0] & cin);
  assign bit_c[3] = bit_g[2]
                  | (bit_p[2] & bit_g[1])
                  | (bit_p[2] & bit_p[1] & bit_g[0])
                  | (bit_p[2] & bit_p[1] & bit_p[0] & cin);

  assign g = bit_g[3]
           | (bit_p[3] & bit_g[2])
           | (bit_p[3] & bit_p[2] & bit_g[1])
           | (bit_p[3] & bit_p[2] & bit_p[1] & bit_g[0]);
  assign p = &bit_p;

  assign cout = g | (p & cin);
  assign s    = bit_p ^ bit_c;

endmodule

// File: rtl/acc_int_add.sv
// Exact W-bit adder built from 4-bit lookahead slices with a rippled group carry;
// {co, c} = a + b, optionally registered one cycle behind the operands.
module acc_int_add
  import acc_int_add_pkg::*;
#(
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int OUT_REG            = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_PATH_BITWIDTH-1:0] a,
  input  logic [DATA_PATH_BITWIDTH-1:0] b,
  output logic [DATA_PATH_BITWIDTH-1:0] c,
  output logic                          co
);

  localparam int W  = DATA_PATH_BITWIDTH;
  localparam int NG = cla_num_groups(W);
  localparam int PW = NG * CLA_GRP;

  logic [PW-1:0] a_pad;
  logic [PW-1:0] b_pad;
  logic [PW-1:0] sum_pad;
  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_p;
  logic [NG-1:0] grp_cout;
  logic [NG:0]   grp_c;
  logic [PW:0]   sum_ext;
  logic [W-1:0]  c_p0;
  logic          co_p0;

  // Zero padding in the top group has p=g=0, so its lowest padded sum bit is exactly the carry into bit W.
  assign a_pad = PW'(a);
  assign b_pad = PW'(b);

  assign grp_c[0] = 1'b0;

  for (genvar i = 0; i < NG; i++) begin : g_grp
    acc_cla4_group u_grp (
      .a    (a_pad[i*CLA_GRP +: CLA_GRP]),
      .b    (b_pad[i*CLA_GRP +: CLA_GRP]),
      .cin  (grp_c[i]),
      .s    (sum_pad[i*CLA_GRP +: CLA_GRP]),
      .g    (grp_g[i]),
      .p    (grp_p[i]),
      .cout (grp_cout[i])
    );
    assign grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
  end

  assign sum_ext = {grp_c[NG], sum_pad};
  assign c_p0    = sum_ext[W-1:0];
  assign co_p0   = sum_ext[W];

  // ---- stage p0 -> p1: optional output register ----
  if (OUT_REG != 0) begin : g_reg
    logic [W-1:0] c_p1;
    logic         co_p1;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        c_p1  <= '0;
        co_p1 <= 1'b0;
      end else begin
        c_p1  <= c_p0;
        co_p1 <= co_p0;
      end
    end

    assign c  = c_p1;
    assign co = co_p1;
  end else begin : g_comb
    assign c  = c_p0;
    assign co = co_p0;
  end

  // Slice carry-outs duplicate the group ripple; padding sum bits and, in the
  // combinational build, clk/rst have no reader.
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst, grp_cout, sum_ext};

endmodule

// File: tb/tb_acc_int_add.sv
// Bench for acc_int_add: combinational 32-bit and 13-bit builds plus a registered 32-bit build,
// all compared against a plain wide-integer sum.
module tb_acc_int_add;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic [31:0] c32;
  logic        co32;
  logic [12:0] a13 = '0;
  logic [12:0] b13 = '0;
  logic [12:0] c13;
  logic        co13;
  logic [31:0] cr;
  logic        cor;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  acc_int_add #(.DATA_PATH_BITWIDTH(32), .OUT_REG(0)) dut_comb32 (
    .clk(clk), .rst(rst), .a(a32), .b(b32), .c(c32), .co(co32)
  );

  acc_int_add #(.DATA_PATH_BITWIDTH(13), .OUT_REG(0)) dut_comb13 (
    .clk(clk), .rst(rst), .a(a13), .b(b13), .c(c13), .co(co13)
  );

  acc_int_add #(.DATA_PATH_BITWIDTH(32), .OUT_REG(1)) dut_reg32 (
    .clk(clk), .rst(rst), .a(a32), .b(b32), .c(cr), .co(cor)
  );

  function automatic logic [32:0] ref32(input logic [31:0] x, input logic [31:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic [13:0] ref13(input logic [12:0] x, input logic [12:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a32 = $urandom;
      b32 = $urandom;
      #1;
      vectors++;
      if ({cor, cr} !== 33'h0) begin
        miscompares++;
        $display("FAIL reset_hold_mid: got %h required 0", {cor, cr});
      end
      @(posedge clk);
      #1;
      vectors++;
      if ({cor, cr} !== 33'h0) begin
        miscompares++;
        $display("FAIL reset_hold_edge: got %h required 0", {cor, cr});
      end
    end
  endtask

  task automatic test_comb_directed();
    logic [31:0] ta [5];
    logic [31:0] tb [5];
    logic [32:0] te [5];
    ta[0] = 32'h0000_0005; tb[0] = 32'h0000_0007; te[0] = 33'h0_0000_000C;
    ta[1] = 32'hFFFF_FFFF; tb[1] = 32'h0000_0001; te[1] = 33'h1_0000_0000;
    ta[2] = 32'h0000_0000; tb[2] = 32'h0000_0000; te[2] = 33'h0_0000_0000;
    ta[3] = 32'hFFFF_FFFF; tb[3] = 32'hFFFF_FFFF; te[3] = 33'h1_FFFF_FFFE;
    ta[4] = 32'h8000_0000; tb[4] = 32'h8000_0000; te[4] = 33'h1_0000_0000;
    for (int i = 0; i < 5; i++) begin
      a32 = ta[i];
      b32 = tb[i];
      #0;
      #1;
      vectors++;
      if ({co32, c32} !== te[i]) begin
        miscompares++;
        $display("FAIL comb32_directed[%0d]: got %h required %h", i, {co32, c32}, te[i]);
      end
    end
  endtask

  task automatic test_w13();
    logic [12:0] ta [4];
    logic [12:0] tb [4];
    logic [13:0] te [4];
    ta[0] = 13'h1FFF; tb[0] = 13'h1FFF; te[0] = 14'h3FFE;
    ta[1] = 13'h1000; tb[1] = 13'h0FFF; te[1] = 14'h1FFF;
    ta[2] = 13'h1FFF; tb[2] = 13'h0001; te[2] = 14'h2000;
    ta[3] = 13'h0000; tb[3] = 13'h0000; te[3] = 14'h0000;
    for (int i = 0; i < 4; i++) begin
      a13 = ta[i];
      b13 = tb[i];
      #1;
      vectors++;
      if ({co13, c13} !== te[i]) begin
        miscompares++;
        $display("FAIL comb13_directed[%0d]: got %h required %h", i, {co13, c13}, te[i]);
      end
    end
  endtask

  task automatic test_random_comb();
    logic [32:0] e32;
    logic [13:0] e13;
    for (int i = 0; i < 10000; i++) begin
      a32 = $urandom;
      b32 = $urandom;
      a13 = 13'($urandom);
      b13 = 13'($urandom);
      if (i % 4 == 0) begin
        a32[7:0] = 8'h00;
        b32[7:0] = 8'h00;
        a13[7:0] = 8'h00;
        b13[7:0] = 8'h00;
      end
      e32 = ref32(a32, b32);
      e13 = ref13(a13, b13);
      #1;
      vectors++;
      if ({co32, c32} !== e32) begin
        miscompares++;
        $display("FAIL comb32_random: a=%h b=%h got %h required %h", a32, b32, {co32, c32}, e32);
      end
      vectors++;
      if ({co13, c13} !== e13) begin
        miscompares++;
        $display("FAIL comb13_random: a=%h b=%h got %h required %h", a13, b13, {co13, c13}, e13);
      end
    end
  endtask

  task automatic test_reg_basic();
    @(negedge clk);
    rst = 1'b1;
    a32 = 32'h10;
    b32 = 32'h20;
    #1;
    vectors++;
    if ({cor, cr} !== 33'h0) begin
      miscompares++;
      $display("FAIL reg_release_before_edge: got %h required 0", {cor, cr});
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({cor, cr} !== 33'h0_0000_0030) begin
      miscompares++;
      $display("FAIL reg_first_edge: got %h required 30", {cor, cr});
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] prev;
    logic [32:0] exp;
    prev = 33'h0_0000_0030;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      a32 = $urandom;
      b32 = $urandom;
      if (i % 8 == 0) b32 = ~a32 + ((i % 16 == 0) ? 32'd1 : 32'd0);
      exp = ref32(a32, b32);
      #1;
      vectors++;
      if ({cor, cr} !== prev) begin
        miscompares++;
        $display("FAIL reg_hold_between_edges: got %h required %h", {cor, cr}, prev);
      end
      @(posedge clk);
      #1;
      vectors++;
      if ({cor, cr} !== exp) begin
        miscompares++;
        $display("FAIL reg_latency1: a=%h b=%h got %h required %h", a32, b32, {cor, cr}, exp);
      end
      prev = exp;
    end
  endtask

  task automatic test_reset_midstream();
    logic [32:0] exp;
    @(negedge clk);
    a32 = 32'h10;
    b32 = 32'h20;
    @(posedge clk);
    #1;
    vectors++;
    if ({cor, cr} !== 33'h0_0000_0030) begin
      miscompares++;
      $display("FAIL midstream_preload: got %h required 30", {cor, cr});
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({cor, cr} !== 33'h0) begin
      miscompares++;
      $display("FAIL midstream_async_clear: got %h required 0", {cor, cr});
    end
    @(negedge clk);
    a32 = 32'h1234_5678;
    b32 = 32'h1111_1111;
    @(posedge clk);
    #1;
    vectors++;
    if ({cor, cr} !== 33'h0) begin
      miscompares++;
      $display("FAIL midstream_held_in_reset: got %h required 0", {cor, cr});
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    a32 = 32'hFFFF_FFF0;
    b32 = 32'h0000_0025;
    exp = ref32(a32, b32);
    #1;
    vectors++;
    if ({cor, cr} !== 33'h0) begin
      miscompares++;
      $display("FAIL midstream_release_no_edge: got %h required 0", {cor, cr});
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({cor, cr} !== exp) begin
      miscompares++;
      $display("FAIL midstream_reload: got %h required %h", {cor, cr}, exp);
    end
  endtask

  initial begin
    test_reset();
    test_comb_directed();
    test_w13();
    test_random_comb();
    test_reg_basic();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
